wbdbgbus_arbiter: RTL and testbench

Two-master Wishbone (pipelined) arbiter that shares one slave bus between the debug bridge (master 0) and a second master such as a CPU or DMA (master 1). It sits between the masters and the memory/peripheral fabric. A grant is held for an entire bus cycle (`cyc` high), and the slave's `ack`/`err`/`data` are routed back only to the granted master. An optional watchdog aborts cycles that the slave never completes.

---
 rtl/wbdbgbus_arbiter.sv | 136 +++++++++++++
 tb/tb_wbdbgbus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbdbgbus_arbiter.sv
// Two-master pipelined Wishbone arbiter: debug bridge (m0) and CPU/DMA (m1) share one slave.
// Define WBDBGBUS_ARB_TIMEOUT_EN to build in the watchdog that aborts cycles a slave never completes.
module wbdbgbus_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CLKS   = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic        o_m0_stall,
  output logic [31:0] o_m0_data,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic        o_m1_stall,
  output logic [31:0] o_m1_data,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

`ifdef WBDBGBUS_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1, S_ABORT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1} state_e;
`endif

  state_e state_q;
  logic   last_q;   // index of the most recently granted master; also the current owner
  logic   gnt0, gnt1, own_cyc, abort_pulse;

  assign gnt0    = (state_q == S_GNT0);
  assign gnt1    = (state_q == S_GNT1);
  assign own_cyc = last_q ? i_m1_cyc : i_m0_cyc;

`ifdef WBDBGBUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CLKS);
  logic [CW-1:0] wdog_q;
  logic          timeout_q;
  logic          wdog_expired;

  assign wdog_expired = (wdog_q == CW'(TIMEOUT_CLKS - 1)) && !i_wb_ack && !i_wb_err;
  assign abort_pulse  = timeout_q;
`else
  assign abort_pulse  = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
`ifdef WBDBGBUS_ARB_TIMEOUT_EN
      wdog_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef WBDBGBUS_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
`ifdef WBDBGBUS_ARB_TIMEOUT_EN
          wdog_q <= '0;
`endif
          // On a tie, m0 wins under fixed priority or when m1 was served last.
          if (i_m0_cyc && (!i_m1_cyc || (FIXED_PRIORITY != 0) || last_q)) begin
            state_q <= S_GNT0;
            last_q  <= 1'b0;
          end else if (i_m1_cyc) begin
            state_q <= S_GNT1;
            last_q  <= 1'b1;
          end
        end
        S_GNT0, S_GNT1: begin
          if (!own_cyc) begin
            state_q <= S_IDLE;
          end
`ifdef WBDBGBUS_ARB_TIMEOUT_EN
          else if (wdog_expired) begin
            state_q   <= S_ABORT;
            timeout_q <= 1'b1;
          end
          if (i_wb_ack || i_wb_err) wdog_q <= '0;
          else                      wdog_q <= wdog_q + 1'b1;
`endif
        end
`ifdef WBDBGBUS_ARB_TIMEOUT_EN
        S_ABORT: begin
          if (!own_cyc) state_q <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Slave side mirrors the owner; everything is forced quiet outside GNT0/GNT1.
  assign o_wb_cyc  = (gnt0 & i_m0_cyc) | (gnt1 & i_m1_cyc);
  assign o_wb_stb  = (gnt0 & i_m0_stb) | (gnt1 & i_m1_stb);
  assign o_wb_we   = (gnt0 & i_m0_we)  | (gnt1 & i_m1_we);
  assign o_wb_addr = gnt0 ? i_m0_addr : (gnt1 ? i_m1_addr : 32'h0);
  assign o_wb_data = gnt0 ? i_m0_data : (gnt1 ? i_m1_data : 32'h0);

  assign o_m0_ack   = gnt0 & i_wb_ack;
  assign o_m0_err   = (gnt0 & i_wb_err) | (abort_pulse & ~last_q);
  assign o_m0_stall = gnt0 ? i_wb_stall : 1'b1;
  assign o_m0_data  = gnt0 ? i_wb_data : 32'h0;

  assign o_m1_ack   = gnt1 & i_wb_ack;
  assign o_m1_err   = (gnt1 & i_wb_err) | (abort_pulse & last_q);
  assign o_m1_stall = gnt1 ? i_wb_stall : 1'b1;
  assign o_m1_data  = gnt1 ? i_wb_data : 32'h0;

  assign o_grant   = {gnt1, gnt0};
  assign o_timeout = abort_pulse;

endmodule

// File: tb/tb_wbdbgbus_arbiter.sv
// Directed bench for wbdbgbus_arbiter with a read-data scoreboard and grant-order queue.
// Watchdog steps run only when WBDBGBUS_ARB_TIMEOUT_EN is defined.
module tb_wbdbgbus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        s_ack, s_err, s_stall;
  logic [31:0] s_rdata;

  logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_wdata;
  logic [1:0]  grant;
  logic        timeout;

  logic        fp_m0_ack, fp_m0_err, fp_m0_stall, fp_m1_ack, fp_m1_err, fp_m1_stall;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic        fp_wb_cyc, fp_wb_stb, fp_wb_we;
  logic [31:0] fp_wb_addr, fp_wb_wdata;
  logic [1:0]  fp_grant;
  logic        fp_timeout;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q_m0[$];
  logic [31:0] q_m1[$];
  logic [1:0]  q_gnt[$];

  always #5 clk = ~clk;

  wbdbgbus_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CLKS(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_data(m0_wdata),
    .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_stall(m0_stall), .o_m0_data(m0_rdata),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_data(m1_wdata),
    .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_stall(m1_stall), .o_m1_data(m1_rdata),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr), .o_wb_data(wb_wdata),
    .i_wb_ack(s_ack), .i_wb_err(s_err), .i_wb_stall(s_stall), .i_wb_data(s_rdata),
    .o_grant(grant), .o_timeout(timeout)
  );

  wbdbgbus_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CLKS(8)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_data(m0_wdata),
    .o_m0_ack(fp_m0_ack), .o_m0_err(fp_m0_err), .o_m0_stall(fp_m0_stall), .o_m0_data(fp_m0_rdata),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_data(m1_wdata),
    .o_m1_ack(fp_m1_ack), .o_m1_err(fp_m1_err), .o_m1_stall(fp_m1_stall), .o_m1_data(fp_m1_rdata),
    .o_wb_cyc(fp_wb_cyc), .o_wb_stb(fp_wb_stb), .o_wb_we(fp_wb_we), .o_wb_addr(fp_wb_addr),
    .o_wb_data(fp_wb_wdata),
    .i_wb_ack(s_ack), .i_wb_err(s_err), .i_wb_stall(s_stall), .i_wb_data(s_rdata),
    .o_grant(fp_grant), .o_timeout(fp_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled on the falling edge; any ack is scored against the queued read data.
  task automatic sample();
    @(negedge clk);
    if (m0_ack) begin
      if (q_m0.size() == 0) check("m0_unexpected_ack", m0_ack, 1'b0);
      else                  check("m0_rdata", m0_rdata, q_m0.pop_front());
    end
    if (m1_ack) begin
      if (q_m1.size() == 0) check("m1_unexpected_ack", m1_ack, 1'b0);
      else                  check("m1_rdata", m1_rdata, q_m1.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next();
    rst = 1'b0;
  endtask

  // Both masters request together; each drops cyc right after being granted, then re-requests.
  task automatic tie_run(input bit fp, input int n_each);
    int         rem0, rem1, cycles;
    logic [1:0] g, prev_g;
    rem0 = n_each; rem1 = n_each; cycles = 0; prev_g = 2'b00;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    while ((rem0 > 0 || rem1 > 0) && cycles < 200) begin
      sample();
      g = fp ? fp_grant : grant;
      if (g != 2'b00 && g != prev_g) begin
        check("tie_idle_gap", prev_g, 2'b00);
        if (q_gnt.size() == 0) check("tie_extra_grant", g, 2'b00);
        else                   check("tie_order", g, q_gnt.pop_front());
      end
      prev_g = g;
      next();
      if (g == 2'b01 && m0_cyc) begin
        m0_cyc = 1'b0; m0_stb = 1'b0; rem0--;
      end else if (!m0_cyc && rem0 > 0) begin
        m0_cyc = 1'b1; m0_stb = 1'b1;
      end
      if (g == 2'b10 && m1_cyc) begin
        m1_cyc = 1'b0; m1_stb = 1'b0; rem1--;
      end else if (!m1_cyc && rem1 > 0) begin
        m1_cyc = 1'b1; m1_stb = 1'b1;
      end
      cycles++;
    end
    check("tie_budget", 32'(cycles < 200), 1);
    check("tie_grants_left", q_gnt.size(), 0);
    sample();
    next();
  endtask

  initial begin
    #100000;
    $display("FAIL time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    s_ack = 0; s_err = 0; s_stall = 0; s_rdata = 0;

    // Reset state
    sample();
    check("rst_grant", grant, 2'b00);
    check("rst_wb_cyc", wb_cyc, 1'b0);
    check("rst_m0_stall", m0_stall, 1'b1);
    check("rst_m1_stall", m1_stall, 1'b1);
    check("rst_timeout", timeout, 1'b0);
    next();
    rst = 1'b0;

    // Single write by m0
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    sample();
    check("t1_grant_req", grant, 2'b00);
    check("t1_m0_stall_req", m0_stall, 1'b1);
    check("t1_wb_cyc_req", wb_cyc, 1'b0);
    next(); sample();
    check("t1_grant", grant, 2'b01);
    check("t1_wb_cyc", wb_cyc, 1'b1);
    check("t1_wb_stb", wb_stb, 1'b1);
    check("t1_wb_we", wb_we, 1'b1);
    check("t1_wb_addr", wb_addr, 32'h10);
    check("t1_wb_data", wb_wdata, 32'hDEADBEEF);
    check("t1_m0_stall", m0_stall, 1'b0);
    check("t1_m1_stall", m1_stall, 1'b1);
    next(); m0_stb = 0; s_ack = 1; s_rdata = 32'h0; q_m0.push_back(32'h0);
    sample();
    check("t1_m0_ack", m0_ack, 1'b1);
    check("t1_m1_ack", m1_ack, 1'b0);
    check("t1_m1_stall_ack", m1_stall, 1'b1);
    check("t1_timeout", timeout, 1'b0);
    next(); s_ack = 0; m0_cyc = 0; m0_we = 0;
    sample();
    check("t1_m0_ack_once", m0_ack, 1'b0);
    check("t1_ack_seen", q_m0.size(), 0);
    next(); sample();
    check("t1_release", grant, 2'b00);
    next();

    // Simultaneous requests: round-robin, then fixed priority
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q_gnt.push_back(2'b01);
      q_gnt.push_back(2'b10);
    end
    tie_run(1'b0, 4);
    for (int i = 0; i < 4; i++) q_gnt.push_back(2'b01);
    for (int i = 0; i < 4; i++) q_gnt.push_back(2'b10);
    tie_run(1'b1, 4);

    // m1 burst of 3 reads, slave stalls the first stb for 2 clocks
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h100; s_stall = 1;
    sample();
    check("t3_m1_stall_req", m1_stall, 1'b1);
    next(); sample();
    check("t3_grant", grant, 2'b10);
    check("t3_m1_stall_0", m1_stall, 1'b1);
    check("t3_wb_addr", wb_addr, 32'h100);
    check("t3_m0_stall", m0_stall, 1'b1);
    next(); sample();
    check("t3_m1_stall_1", m1_stall, 1'b1);
    next(); s_stall = 0;
    sample();
    check("t3_m1_stall_off", m1_stall, 1'b0);
    next(); m1_addr = 32'h104; s_ack = 1; s_rdata = 32'h1; q_m1.push_back(32'h1);
    sample();
    check("t3_m0_ack_a", m0_ack, 1'b0);
    check("t3_m0_data_a", m0_rdata, 32'h0);
    next(); m1_addr = 32'h108; s_rdata = 32'h2; q_m1.push_back(32'h2);
    sample();
    check("t3_m0_ack_b", m0_ack, 1'b0);
    next(); m1_stb = 0; s_rdata = 32'h3; q_m1.push_back(32'h3);
    sample();
    check("t3_m0_data_c", m0_rdata, 32'h0);
    next(); s_ack = 0; s_rdata = 0; m1_cyc = 0;
    sample();
    check("t3_acks_seen", q_m1.size(), 0);
    next(); sample();
    next();

    // Ack coincident with m0 release while m1 waits
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h20;
    sample();
    next(); m1_cyc = 1; m1_stb = 1; m1_addr = 32'h300;
    sample();
    check("t4_grant_m0", grant, 2'b01);
    check("t4_m1_wait_stall", m1_stall, 1'b1);
    next(); m0_cyc = 0; m0_stb = 0; s_ack = 1; s_rdata = 32'hCAFE0001; q_m0.push_back(32'hCAFE0001);
    sample();
    check("t4_m0_ack", m0_ack, 1'b1);
    check("t4_m1_ack", m1_ack, 1'b0);
    check("t4_grant_hold", grant, 2'b01);
    next(); s_ack = 0; s_rdata = 0;
    sample();
    check("t4_idle_gap", grant, 2'b00);
    check("t4_ack_seen", q_m0.size(), 0);
    next(); sample();
    check("t4_grant_m1", grant, 2'b10);
    next(); m1_cyc = 0; m1_stb = 0;
    sample();
    next(); sample();
    next();

    // Asynchronous reset mid-burst in GNT1
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h55;
    sample();
    next(); sample();
    check("t5_grant_m1", grant, 2'b10);
    check("t5_wb_cyc_pre", wb_cyc, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_wb_cyc", wb_cyc, 1'b0);
    check("t5_wb_stb", wb_stb, 1'b0);
    check("t5_wb_we", wb_we, 1'b0);
    check("t5_wb_addr", wb_addr, 32'h0);
    check("t5_wb_data", wb_wdata, 32'h0);
    check("t5_grant", grant, 2'b00);
    check("t5_m0_stall", m0_stall, 1'b1);
    check("t5_m1_stall", m1_stall, 1'b1);
    check("t5_timeout", timeout, 1'b0);
    next();
    rst = 1'b0; m1_we = 0; m0_cyc = 1; m0_stb = 1; m0_addr = 32'h30;
    sample();
    check("t5_idle_after_rst", grant, 2'b00);
    next(); sample();
    check("t5_tie_to_m0", grant, 2'b01);
    next(); m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    sample();
    next(); sample();
    next();

`ifdef WBDBGBUS_ARB_TIMEOUT_EN
    // Watchdog with a slave that never responds
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h40;
    sample();
    check("t6_grant_req", grant, 2'b00);
    for (int k = 0; k < 8; k++) begin
      next();
      if (k == 1) m0_stb = 0;
      sample();
      check("t6_wb_cyc", wb_cyc, 1'b1);
      check("t6_no_err", m0_err, 1'b0);
      check("t6_no_timeout", timeout, 1'b0);
    end
    next(); sample();
    check("t6_err", m0_err, 1'b1);
    check("t6_timeout", timeout, 1'b1);
    check("t6_abort_wb_cyc", wb_cyc, 1'b0);
    check("t6_abort_grant", grant, 2'b00);
    check("t6_m1_err", m1_err, 1'b0);
    next(); s_ack = 1;
    sample();
    check("t6_err_once", m0_err, 1'b0);
    check("t6_timeout_once", timeout, 1'b0);
    check("t6_late_ack_dropped", m0_ack, 1'b0);
    check("t6_abort_hold_cyc", wb_cyc, 1'b0);
    next(); s_ack = 0; m0_cyc = 0; m1_cyc = 1; m1_stb = 1;
    sample();
    check("t6_abort_exit", grant, 2'b00);
    next(); sample();
    check("t6_idle", grant, 2'b00);
    next(); sample();
    check("t6_regrant", grant, 2'b10);
    next(); m1_cyc = 0; m1_stb = 0;
    sample();
    next();
`endif

    check("sb_m0_drained", q_m0.size(), 0);
    check("sb_m1_drained", q_m1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
